// File: rtl/lockbox_frontend_pkg.sv
// lockbox_frontend_pkg: opcodes, response status codes and FSM states for the lockbox front end
package lockbox_frontend_pkg;
  localparam logic [7:0] OP_STORE = 8'h01;
  localparam logic [7:0] OP_GET = 8'h02;
  localparam logic [7:0] ST_ACK = 8'h00;
  localparam logic [7:0] ST_DATA = 8'h01;
  localparam logic [7:0] ST_BADOP = 8'hFF;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RX_SECRET = 3'd1,
    S_RX_PASSWORD = 3'd2,
    S_ISSUE = 3'd3,
    S_CAPTURE = 3'd4,
    S_TX = 3'd5
  } state_e;
endpackage

// File: rtl/lockbox_frontend_if.sv
// lockbox_frontend_if: host byte streams plus the lockbox core transaction bus
interface lockbox_frontend_if #(parameter int WIDTH = 128);
  logic rx_valid;
  logic rx_ready;
  logic [7:0] rx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] tx_data;
  logic lb_en;
  logic lb_op;
  logic [WIDTH-1:0] lb_secret;
  logic [WIDTH-1:0] lb_password;
  logic [WIDTH-1:0] lb_out;
  modport master (
    input rx_valid, rx_data, tx_ready, lb_out,
    output rx_ready, tx_valid, tx_data, lb_en, lb_op, lb_secret, lb_password
  );
  modport slave (
    output rx_valid, rx_data, tx_ready, lb_out,
    input rx_ready, tx_valid, tx_data, lb_en, lb_op, lb_secret, lb_password
  );
endinterface

// File: rtl/lockbox_frontend.sv
// lockbox_frontend: deserializes store/get frames, pulses the core once, serializes the response
module lockbox_frontend
  import lockbox_frontend_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input logic clk,
  input logic resetn,
  lockbox_frontend_if.master bus
);
  localparam int BYTES = WIDTH / 8;
  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
  localparam logic [CW-1:0] FULL = CW'(BYTES);
  state_e state;
  logic op_q;
  logic [7:0] hdr;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] secret, password, resp;
  logic rx_hs, tx_hs, issue, tx_st, store, get;
  assign issue = state == S_ISSUE;
  assign tx_st = state == S_TX;
  assign bus.rx_ready = resetn && (state == S_IDLE || state == S_RX_SECRET || state == S_RX_PASSWORD);
  assign rx_hs = bus.rx_valid && bus.rx_ready;
  assign tx_hs = tx_st && bus.tx_ready;
  assign store = bus.rx_data == OP_STORE;
  assign get = bus.rx_data == OP_GET;
  assign bus.tx_valid = tx_st;
  // cnt == 0 in TX selects the header; 1..BYTES walk the payload
  assign bus.tx_data = !tx_st ? 8'h00 : (cnt == '0 ? hdr : resp[WIDTH-1 -: 8]);
  assign bus.lb_en = issue;
  assign bus.lb_op = issue && op_q;
  assign bus.lb_secret = (issue && op_q) ? secret : '0;
  assign bus.lb_password = issue ? password : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      op_q <= 1'b0;
      hdr <= 8'h00;
      cnt <= '0;
      secret <= '0;
      password <= '0;
      resp <= '0;
    end else begin
      case (state)
        S_IDLE: if (rx_hs) begin
          op_q <= store;
          hdr <= store ? ST_ACK : get ? ST_DATA : ST_BADOP;
          state <= store ? S_RX_SECRET : get ? S_RX_PASSWORD : S_TX;
        end
        S_RX_SECRET: if (rx_hs) begin
          secret <= (secret << 8) | WIDTH'(bus.rx_data);
          cnt <= cnt == LAST ? '0 : cnt + CW'(1);
          if (cnt == LAST) state <= S_RX_PASSWORD;
        end
        S_RX_PASSWORD: if (rx_hs) begin
          password <= (password << 8) | WIDTH'(bus.rx_data);
          cnt <= cnt == LAST ? '0 : cnt + CW'(1);
          if (cnt == LAST) state <= S_ISSUE;
        end
        S_ISSUE: begin
          secret <= '0;
          password <= '0;
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          resp <= op_q ? '0 : bus.lb_out;
          state <= S_TX;
        end
        S_TX: if (tx_hs) begin
          if (cnt == '0) begin
            if (hdr == ST_DATA) cnt <= CW'(1);
            else state <= S_IDLE;
          end else begin
            resp <= resp << 8;
            cnt <= cnt == FULL ? '0 : cnt + CW'(1);
            if (cnt == FULL) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lockbox_frontend.sv
// tb_lockbox_frontend: directed vectors against WIDTH=16 and WIDTH=128 front ends with a behavioural core
module tb_lockbox_frontend;
  import lockbox_frontend_pkg::*;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sel = 1'b0;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  always #5 clk = ~clk;
  lockbox_frontend_if #(.WIDTH(16)) i16();
  lockbox_frontend_if #(.WIDTH(128)) i128();
  lockbox_frontend #(.WIDTH(16)) dut16 (.clk(clk), .resetn(resetn), .bus(i16));
  lockbox_frontend #(.WIDTH(128)) dut128 (.clk(clk), .resetn(resetn), .bus(i128));
  assign i16.rx_valid = rx_valid & ~sel;
  assign i128.rx_valid = rx_valid & sel;
  assign i16.rx_data = rx_data;
  assign i128.rx_data = rx_data;
  assign i16.tx_ready = tx_ready & ~sel;
  assign i128.tx_ready = tx_ready & sel;
  logic rdy, tv, en_c;
  logic [7:0] td;
  assign rdy = sel ? i128.rx_ready : i16.rx_ready;
  assign tv = sel ? i128.tx_valid : i16.tx_valid;
  assign td = sel ? i128.tx_data : i16.tx_data;
  assign en_c = sel ? i128.lb_en : i16.lb_en;
  // behavioural lockbox cores: store keeps secret/password, get returns secret only on a match
  logic [15:0] k16s, k16p, o16;
  logic [127:0] k128s, k128p, o128;
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      k16s <= '0; k16p <= '0; o16 <= '0;
    end else if (i16.lb_en) begin
      if (i16.lb_op) begin
        k16s <= i16.lb_secret; k16p <= i16.lb_password; o16 <= '0;
      end else o16 <= (i16.lb_password == k16p) ? k16s : '0;
    end
  always @(posedge clk or negedge resetn)
    if (!resetn) begin
      k128s <= '0; k128p <= '0; o128 <= '0;
    end else if (i128.lb_en) begin
      if (i128.lb_op) begin
        k128s <= i128.lb_secret; k128p <= i128.lb_password; o128 <= '0;
      end else o128 <= (i128.lb_password == k128p) ? k128s : '0;
    end
  assign i16.lb_out = o16;
  assign i128.lb_out = o128;
  int checks = 0;
  int fails = 0;
  int en16 = 0;
  int en128 = 0;
  logic op16, op128;
  logic [15:0] s16, p16;
  logic [127:0] s128, p128;
  always @(negedge clk) begin
    checks += 4;
    if (i16.lb_en) begin
      en16++; op16 = i16.lb_op; s16 = i16.lb_secret; p16 = i16.lb_password;
      if (!i16.lb_op && i16.lb_secret != '0) begin fails++; $display("FAIL get_secret16: got %h required 0", i16.lb_secret); end
    end else if (i16.lb_op || i16.lb_secret != '0 || i16.lb_password != '0) begin
      fails++; $display("FAIL idle_operands16: op %b sec %h pw %h required all 0", i16.lb_op, i16.lb_secret, i16.lb_password);
    end
    if (i128.lb_en) begin
      en128++; op128 = i128.lb_op; s128 = i128.lb_secret; p128 = i128.lb_password;
    end else if (i128.lb_op || i128.lb_secret != '0 || i128.lb_password != '0) begin
      fails++; $display("FAIL idle_operands128: op %b sec %h pw %h required all 0", i128.lb_op, i128.lb_secret, i128.lb_password);
    end
    if (i16.rx_ready && i16.tx_valid) begin fails++; $display("FAIL overlap16: rx_ready and tx_valid both 1"); end
    if (i128.rx_ready && i128.tx_valid) begin fails++; $display("FAIL overlap128: rx_ready and tx_valid both 1"); end
  end
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && !rdy; i++) @(negedge clk);
    chk("rx_ready_wait", 128'(rdy), 128'(1));
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic recv_byte(input string n, input logic [7:0] e);
    tx_ready = 1'b1;
    for (int i = 0; i < 50 && !tv; i++) @(negedge clk);
    chk({n, "_valid"}, 128'(tv), 128'(1));
    chk(n, 128'(td), 128'(e));
    @(posedge clk);
    #1 tx_ready = 1'b0;
  endtask
  task automatic latency(input int lat, input bit en);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("lat_en", 128'(en_c), 128'(en && k == 1));
      chk("lat_txv", 128'(tv), 128'(k == lat));
    end
  endtask
  typedef struct {
    logic [7:0] b[5];
    int nb;
    logic [7:0] r[3];
    int nr;
    bit en;
    bit op;
    logic [15:0] sec;
    logic [15:0] pw;
    int lat;
  } vec_t;
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1);
  end
  initial begin
    vec_t v[8];
    int e0;
    logic [7:0] d0;
    logic [7:0] q[$];
    logic [127:0] exp_s, exp_p;
    v[0] = '{'{8'h01, 8'hAB, 8'hCD, 8'h12, 8'h34}, 5, '{8'h00, 8'h00, 8'h00}, 1, 1'b1, 1'b1, 16'hABCD, 16'h1234, 3};
    v[1] = '{'{8'h02, 8'h12, 8'h34, 8'h00, 8'h00}, 3, '{8'h01, 8'hAB, 8'hCD}, 3, 1'b1, 1'b0, 16'h0000, 16'h1234, 3};
    v[2] = '{'{8'h02, 8'h00, 8'h01, 8'h00, 8'h00}, 3, '{8'h01, 8'h00, 8'h00}, 3, 1'b1, 1'b0, 16'h0000, 16'h0001, 3};
    v[3] = '{'{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'hFF, 8'h00, 8'h00}, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1};
    v[4] = '{'{8'h02, 8'h12, 8'h34, 8'h00, 8'h00}, 3, '{8'h01, 8'hAB, 8'hCD}, 3, 1'b1, 1'b0, 16'h0000, 16'h1234, 3};
    v[5] = '{'{8'h01, 8'h11, 8'h22, 8'h33, 8'h44}, 5, '{8'h00, 8'h00, 8'h00}, 1, 1'b1, 1'b1, 16'h1122, 16'h3344, 3};
    v[6] = '{'{8'h02, 8'h33, 8'h44, 8'h00, 8'h00}, 3, '{8'h01, 8'h11, 8'h22}, 3, 1'b1, 1'b0, 16'h0000, 16'h3344, 3};
    v[7] = '{'{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'hFF, 8'h00, 8'h00}, 1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1};
    repeat (2) @(negedge clk);
    chk("rst_rx_ready16", 128'(i16.rx_ready), 128'(0));
    chk("rst_rx_ready128", 128'(i128.rx_ready), 128'(0));
    chk("rst_tx", {i16.tx_valid, i16.tx_data, i128.tx_valid, i128.tx_data}, '0);
    chk("rst_lb", {i16.lb_en, i16.lb_op, i128.lb_en, i128.lb_op}, '0);
    resetn = 1'b1;
    #1 chk("post_rst_rx_ready", {i16.rx_ready, i128.rx_ready}, 128'(2'b11));
    for (int i = 0; i < 8; i++) begin
      e0 = en16;
      for (int j = 0; j < v[i].nb; j++) send_byte(v[i].b[j], i[0]);
      latency(v[i].lat, v[i].en);
      for (int j = 0; j < v[i].nr; j++) recv_byte("rsp", v[i].r[j]);
      chk("en_count", 128'(en16 - e0), 128'(v[i].en));
      if (v[i].en) chk("lb_fields", {op16, s16, p16}, {v[i].op, v[i].sec, v[i].pw});
    end
    // get under tx backpressure with irregular rx gaps
    e0 = en16;
    q = '{8'h02, 8'h33, 8'h44};
    foreach (q[j]) send_byte(q[j], 1'b1);
    for (int i = 0; i < 50 && !tv; i++) @(negedge clk);
    d0 = td;
    chk("bp_first", 128'(d0), 128'(ST_DATA));
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {tv, td}, {1'b1, d0});
    end
    recv_byte("bp_hdr", ST_DATA);
    repeat (3) @(negedge clk);
    chk("bp_hold_byte", {tv, td}, {1'b1, 8'h11});
    recv_byte("bp_p0", 8'h11);
    recv_byte("bp_p1", 8'h22);
    chk("bp_en_count", 128'(en16 - e0), 128'(1));
    // reset in the middle of a store frame
    e0 = en16;
    send_byte(8'h01, 1'b0);
    send_byte(8'hAB, 1'b0);
    @(negedge clk);
    resetn = 1'b0;
    #1 chk("midrst_out", {rdy, tv, td, en_c, i16.lb_secret, i16.lb_password}, '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 chk("midrst_ready", 128'(rdy), 128'(1));
    chk("midrst_no_en", 128'(en16 - e0), 128'(0));
    q = '{8'h01, 8'hAB, 8'hCD, 8'h12, 8'h34};
    foreach (q[j]) send_byte(q[j], 1'b0);
    latency(3, 1'b1);
    recv_byte("midrst_ack", ST_ACK);
    chk("midrst_fields", {op16, s16, p16}, {1'b1, 16'hABCD, 16'h1234});
    q = '{8'h02, 8'h12, 8'h34};
    foreach (q[j]) send_byte(q[j], 1'b0);
    latency(3, 1'b1);
    recv_byte("midrst_hdr", ST_DATA);
    recv_byte("midrst_p0", 8'hAB);
    recv_byte("midrst_p1", 8'hCD);
    // WIDTH=128: 33-byte store then 17-byte get
    sel = 1'b1;
    #1;
    e0 = en128;
    exp_s = '0;
    exp_p = '0;
    q = '{8'h01};
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'h10 + 8'(i));
      exp_s = {exp_s[119:0], 8'h10 + 8'(i)};
    end
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'hC0 + 8'(i));
      exp_p = {exp_p[119:0], 8'hC0 + 8'(i)};
    end
    foreach (q[j]) send_byte(q[j], 1'b0);
    latency(3, 1'b1);
    recv_byte("w128_ack", ST_ACK);
    chk("w128_store_fields", {op128, s128}, {1'b1, exp_s});
    chk("w128_store_pw", p128, exp_p);
    q = '{8'h02};
    for (int i = 0; i < 16; i++) q.push_back(8'hC0 + 8'(i));
    foreach (q[j]) send_byte(q[j], 1'b1);
    latency(3, 1'b1);
    recv_byte("w128_hdr", ST_DATA);
    for (int i = 0; i < 16; i++) recv_byte("w128_payload", 8'h10 + 8'(i));
    chk("w128_en_count", 128'(en128 - e0), 128'(2));
    @(negedge clk);
    chk("w128_idle", {i128.rx_ready, i128.tx_valid}, 128'(2'b10));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/lockbox_frontend.md
# lockbox_frontend

Byte-stream command front end that sits directly upstream of the lockbox core. It deserializes host commands (store / get) from an 8-bit valid/ready stream and issues a single-cycle `en` transaction to the core. It then captures the core's registered `out` and serializes a response frame back to the host. Operand registers are zeroed after every issue so no secret or password lingers in the front end.

## Interface
- `WIDTH`, default 128: operand width in bits; must be a multiple of 8 and at least 8. Define `BYTES = WIDTH/8`.
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: host byte valid.
- `rx_ready` out 1: front end accepts a byte.
- `rx_data` in 8: host byte.
- `tx_valid` out 1: response byte valid.
- `tx_ready` in 1: host accepts the response byte.
- `tx_data` out 8: response byte.
- `lb_en` out 1: lockbox enable, a one-cycle pulse.
- `lb_op` out 1: 1 = store, 0 = get.
- `lb_secret` out WIDTH: secret operand; zero whenever `lb_en` = 0.
- `lb_password` out WIDTH: password operand; zero whenever `lb_en` = 0.
- `lb_out` in WIDTH: lockbox result, registered in the core.

## Operation
- **Frame format (host→block):**
  - One opcode byte.
  - Operand bytes, most-significant byte first.
  - `OP_STORE` = 0x01: BYTES secret bytes, then BYTES password bytes.
  - `OP_GET` = 0x02: BYTES password bytes only.
- **States:** IDLE, RX_SECRET, RX_PASSWORD, ISSUE, CAPTURE, TX.
- **IDLE:** `rx_ready` = 1. On handshake:
  - 0x01 → RX_SECRET, with `op_q` = 1.
  - 0x02 → RX_PASSWORD, with `op_q` = 0.
  - Any other value → TX, with header 0xFF and no payload.
- **RX_SECRET / RX_PASSWORD:** `rx_ready` = 1.
  - Each handshake shifts the byte into the field register: `reg <= {reg[WIDTH-9:0], rx_data}`.
  - Byte counter `cnt` has width `$clog2(BYTES+1)`. It resets to 0 on entry to each field and on field completion; it never wraps mid-field.
  - After byte BYTES of the secret → RX_PASSWORD.
  - After byte BYTES of the password → ISSUE.
- **ISSUE (1 cycle):**
  - `rx_ready` = 0.
  - `lb_en` = 1, `lb_op` = `op_q`.
  - `lb_secret` = secret register if `op_q` = 1, else 0.
  - `lb_password` = password register.
  - Both operand registers clear to 0 at the end of the cycle. → CAPTURE.
- **CAPTURE (1 cycle):**
  - If `op_q` = 0, latch `lb_out` into the response register.
  - If `op_q` = 1, load 0 into the response register.
  - → TX.
- **TX:** `rx_ready` = 0. Bytes are sent in this order:
  - Header: 0x00 for store ack, 0x01 for get, 0xFF for bad opcode.
  - For get only: BYTES payload bytes, MSB first, shifting the response register left by 8 per handshake.
  - After the last handshake, the response register is zero and the state → IDLE.
- A wrong password is not distinguished: the core returns 0, and the block forwards BYTES zero bytes with header 0x01.

## Timing
- **Reset:** asynchronous assertion, synchronous deassertion assumed from the system. Every register clears to 0 and the state → IDLE.
- **Output values during and after reset:** `rx_ready` = 0 while `resetn` = 0 and 1 in the first cycle after. `tx_valid`, `tx_data`, `lb_en`, `lb_op`, `lb_secret` and `lb_password` are all 0.
- **Reset mid-frame or mid-TX:** the partial frame is discarded with no `lb_en` pulse, and all operand and response registers are zeroed.
- **Latency:** last operand handshake in cycle t → `lb_en` in t+1 → capture in t+2 → `tx_valid` with header from t+3.
- **Bad opcode:** handshake in t → header from t+1.
- **Handshake rules:**
  - A byte transfers when valid && ready.
  - `tx_valid` and `tx_data` stay stable until `tx_ready`.
  - `tx_valid` may be asserted back-to-back for consecutive bytes.
- **No overlap:** `rx_ready` and `tx_valid` are never 1 in the same cycle. Host bytes offered during ISSUE, CAPTURE or TX are left pending, not dropped.
- `lb_en` is high for exactly one cycle per complete valid frame, never otherwise.

## Structure
- **Package `lockbox_frontend_pkg`:**
  - Opcodes `OP_STORE` = 8'h01, `OP_GET` = 8'h02.
  - Status codes `ST_ACK` = 8'h00, `ST_DATA` = 8'h01, `ST_BADOP` = 8'hFF.
  - State enum.
- Single module, no sub-module; the two shift registers and one counter are inlined.
- The top-level integration instantiates `lockbox_frontend` beside the core and wires `lb_*` directly to it.

## Test plan
- **Store then get, correct password** (WIDTH = 16): send 01 AB CD 12 34 → one `lb_en` with op = 1, secret 0xABCD, password 0x1234, response 00. Then send 02 12 34 → response 01 AB CD.
- **Get with wrong password** after a store of 0xABCD/0x1234: send 02 00 01 → response 01 00 00; no nonzero `lb_secret` is ever observed.
- **Bad opcode:** send 0x7E → response FF only, no `lb_en`. A following 02 12 34 frame is then parsed normally.
- **Backpressure:** `tx_ready` held low for 5 cycles during the get response → `tx_data` is stable and no byte is lost. With `rx_valid` gaps of random length, the frame is still assembled correctly.
- **Reset mid-frame:** assert `resetn` = 0 after 01 AB → outputs go 0 immediately with no `lb_en`. A subsequent full store frame behaves as in scenario 1.
- **WIDTH = 128 regression:** a 33-byte store then a 17-byte get returns the 16-byte secret MSB first. `lb_secret` and `lb_password` are 0 in every non-ISSUE cycle.
